key_event_conditioner: RTL and testbench

//  Front-end for the two DE10-Lite push buttons. Synchronises and debounces the active-low KEY[1:0] pins.

---
 rtl/key_event_conditioner.sv | 156 +++++++++++++++
 tb/tb_key_event_conditioner.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_conditioner.sv
// Push-button front end: synchronise, debounce and classify KEY[1:0] presses
// into single-cycle key0 / key1 / chord events used directly as clock enables.
module key_event_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned CHORD_CYCLES    = 2_500_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] KEY,
  output logic [1:0] key_state,
  output logic       key0_pulse,
  output logic       key1_pulse,
  output logic       both_pulse
);

  localparam int unsigned CNT_W = $clog2(CHORD_CYCLES + 1);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_LAST = CNT_W'(CHORD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ARMED    = 2'd1,
    CHORD    = 2'd2,
    WAIT_REL = 2'd3
  } state_t;

  logic [1:0]       r_sync1;
  logic [1:0]       r_sync2;
  logic [1:0]       w_pressed;
  logic [CNT_W-1:0] r_db_cnt [2];
  logic [1:0]       r_key_state;
  logic [1:0]       r_key_prev;
  logic [1:0]       w_rise;
  logic [1:0]       w_fall;
  logic             w_other_rise;
  logic             w_own_fall;

  state_t           r_state;
  logic             r_sel;
  logic [CNT_W-1:0] r_win;
  logic             r_key0_pulse;
  logic             r_key1_pulse;
  logic             r_both_pulse;

  // Two-flop synchroniser; pins idle high (released) out of reset
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 2'b11;
      r_sync2 <= 2'b11;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pressed = ~r_sync2;

  // Per-key debounce: a level change is accepted only after it holds steadily
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_state <= 2'b00;
      for (int k = 0; k < 2; k++) begin
        r_db_cnt[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (w_pressed[k] == r_key_state[k]) begin
          r_db_cnt[k] <= '0;
        end else if (r_db_cnt[k] == DB_LAST) begin
          r_key_state[k] <= ~r_key_state[k];
          r_db_cnt[k]    <= '0;
        end else begin
          r_db_cnt[k] <= r_db_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // Previous debounced level for press/release edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_key_prev <= 2'b00;
    end else begin
      r_key_prev <= r_key_state;
    end
  end

  assign w_rise       = r_key_state & ~r_key_prev;
  assign w_fall       = ~r_key_state & r_key_prev;
  assign w_other_rise = w_rise[~r_sel];
  assign w_own_fall   = w_fall[r_sel];

  // Press classifier: tap, hold-timeout or chord, one event per episode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sel        <= 1'b0;
      r_win        <= '0;
      r_key0_pulse <= 1'b0;
      r_key1_pulse <= 1'b0;
      r_both_pulse <= 1'b0;
    end else begin
      r_key0_pulse <= 1'b0;
      r_key1_pulse <= 1'b0;
      r_both_pulse <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_rise == 2'b11) begin
            r_both_pulse <= 1'b1;
            r_state      <= CHORD;
          end else if (w_rise[0]) begin
            r_sel   <= 1'b0;
            r_win   <= '0;
            r_state <= ARMED;
          end else if (w_rise[1]) begin
            r_sel   <= 1'b1;
            r_win   <= '0;
            r_state <= ARMED;
          end
        end
        ARMED: begin
          // Window counter saturates rather than wrapping
          if (r_win != WIN_LAST) begin
            r_win <= r_win + CNT_W'(1);
          end
          if (w_other_rise) begin
            r_both_pulse <= 1'b1;
            r_state      <= CHORD;
          end else if (w_own_fall) begin
            r_key0_pulse <= ~r_sel;
            r_key1_pulse <= r_sel;
            r_state      <= IDLE;
          end else if (r_win == WIN_LAST) begin
            r_key0_pulse <= ~r_sel;
            r_key1_pulse <= r_sel;
            r_state      <= WAIT_REL;
          end
        end
        CHORD, WAIT_REL: begin
          if (r_key_state == 2'b00) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign key_state  = r_key_state;
  assign key0_pulse = r_key0_pulse;
  assign key1_pulse = r_key1_pulse;
  assign both_pulse = r_both_pulse;

endmodule

// File: tb/tb_key_event_conditioner.sv
// Bench for key_event_conditioner with short debounce/chord windows.
// Expected pulses (kind + cycle) are queued as stimulus is driven and
// matched by a monitor whenever the DUT emits a pulse.
module tb_key_event_conditioner;

  localparam int unsigned DB = 4;
  localparam int unsigned CH = 20;

  typedef struct {
    int kind;   // 1 = key0, 2 = key1, 3 = both
    int cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [1:0] KEY;
  logic [1:0] key_state;
  logic       key0_pulse;
  logic       key1_pulse;
  logic       both_pulse;

  int   cyc   = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb[$];

  key_event_conditioner #(
    .DEBOUNCE_CYCLES(DB),
    .CHORD_CYCLES   (CH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .KEY       (KEY),
    .key_state (key_state),
    .key0_pulse(key0_pulse),
    .key1_pulse(key1_pulse),
    .both_pulse(both_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: every pulse must match the head of the scoreboard
  always @(negedge clk) begin : mon
    int   kind;
    int   nhot;
    exp_t e;
    kind = 0;
    nhot = int'(key0_pulse) + int'(key1_pulse) + int'(both_pulse);
    if (key0_pulse) kind = 1;
    if (key1_pulse) kind = 2;
    if (both_pulse) kind = 3;
    if (nhot > 1) begin
      n_vec++;
      n_err++;
      $display("FAIL onehot cyc=%0d got k0=%b k1=%b both=%b want at most one", cyc, key0_pulse, key1_pulse, both_pulse);
    end else if (kind != 0) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_pulse cyc=%0d got kind=%0d want none", cyc, kind);
      end else begin
        e = sb.pop_front();
        if (kind !== e.kind || cyc !== e.cyc) begin
          n_err++;
          $display("FAIL pulse got kind=%0d cyc=%0d want kind=%0d cyc=%0d", kind, cyc, e.kind, e.cyc);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got no finish want finish", cyc);
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.cyc  = at;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    KEY = 2'b11;
    tick(3);
    n_vec++;
    if ({key_state, key0_pulse, key1_pulse, both_pulse} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_outputs got %b want 00000", {key_state, key0_pulse, key1_pulse, both_pulse});
    end
    rst = 1'b0;
    tick(10);
    n_vec++;
    if (key_state !== 2'b00) begin
      n_err++;
      $display("FAIL reset_idle key_state got %b want 00", key_state);
    end
  endtask

  task automatic test_glitch();
    KEY[0] = 1'b0;
    tick(3);
    KEY[0] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      n_vec++;
      if (key_state !== 2'b00) begin
        n_err++;
        $display("FAIL glitch key_state cyc=%0d got %b want 00", cyc, key_state);
      end
    end
  endtask

  task automatic test_bouncy_tap();
    int s;
    for (int i = 0; i < 8; i++) begin
      KEY[0] = i[0];
      tick(1);
    end
    s = cyc;
    KEY[0] = 1'b0;
    push(1, s + 19);
    tick(5);
    n_vec++;
    if (key_state !== 2'b00) begin
      n_err++;
      $display("FAIL bouncy_pre key_state got %b want 00", key_state);
    end
    tick(1);
    n_vec++;
    if (key_state !== 2'b01) begin
      n_err++;
      $display("FAIL bouncy_rise key_state got %b want 01", key_state);
    end
    tick(6);
    KEY[0] = 1'b1;
    tick(30);
  endtask

  task automatic test_long_hold();
    int c;
    c = cyc;
    KEY[1] = 1'b0;
    push(2, c + 27);
    tick(6);
    n_vec++;
    if (key_state !== 2'b10) begin
      n_err++;
      $display("FAIL hold_rise key_state got %b want 10", key_state);
    end
    tick(94);
    KEY[1] = 1'b1;
    tick(30);
  endtask

  task automatic test_chord();
    int c;
    c = cyc;
    KEY[0] = 1'b0;
    push(3, c + 15);
    tick(8);
    KEY[1] = 1'b0;
    tick(6);
    n_vec++;
    if (key_state !== 2'b11) begin
      n_err++;
      $display("FAIL chord_state key_state got %b want 11", key_state);
    end
    tick(44);
    KEY = 2'b11;
    tick(30);
  endtask

  task automatic test_simultaneous();
    int c;
    c = cyc;
    KEY = 2'b00;
    push(3, c + 7);
    tick(5);
    n_vec++;
    if (key_state !== 2'b00) begin
      n_err++;
      $display("FAIL simul_pre key_state got %b want 00", key_state);
    end
    tick(1);
    n_vec++;
    if (key_state !== 2'b11) begin
      n_err++;
      $display("FAIL simul_rise key_state got %b want 11", key_state);
    end
    tick(10);
    KEY = 2'b11;
    tick(30);
  endtask

  task automatic test_back_to_back();
    int c;
    for (int t = 0; t < 2; t++) begin
      c = cyc;
      KEY[1] = 1'b0;
      push(2, c + 17);
      tick(10);
      KEY[1] = 1'b1;
      tick(12);
    end
    tick(20);
  endtask

  task automatic test_mid_reset();
    int c;
    c = cyc;
    KEY[0] = 1'b0;
    tick(10);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    n_vec++;
    if ({key_state, key0_pulse, key1_pulse, both_pulse} !== 5'b0) begin
      n_err++;
      $display("FAIL midrst_out got %b want 00000", {key_state, key0_pulse, key1_pulse, both_pulse});
    end
    push(1, c + 39);
    tick(1);
    n_vec++;
    if ({key_state, key0_pulse, key1_pulse, both_pulse} !== 5'b0) begin
      n_err++;
      $display("FAIL midrst_after got %b want 00000", {key_state, key0_pulse, key1_pulse, both_pulse});
    end
    tick(4);
    n_vec++;
    if (key_state !== 2'b00) begin
      n_err++;
      $display("FAIL midrst_pre key_state got %b want 00", key_state);
    end
    tick(1);
    n_vec++;
    if (key_state !== 2'b01) begin
      n_err++;
      $display("FAIL midrst_rise key_state got %b want 01", key_state);
    end
    tick(27);
    KEY[0] = 1'b1;
    tick(30);
  endtask

  task automatic check_drained(input string name);
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL %s missing_pulses got %0d outstanding want 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    rst = 1'b1;
    KEY = 2'b11;
    test_reset();
    check_drained("reset");
    test_glitch();
    check_drained("glitch");
    test_bouncy_tap();
    check_drained("bouncy");
    test_long_hold();
    check_drained("hold");
    test_chord();
    check_drained("chord");
    test_simultaneous();
    check_drained("simul");
    test_back_to_back();
    check_drained("b2b");
    test_mid_reset();
    check_drained("midrst");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
